// File: rtl/disp_capture_if.sv
// Display-bus capture interface: raw CA/SEG bus in, decoded digits out.
// master drives the display bus, slave is the capture block.
interface disp_capture_if;
  logic       CA_IN;
  logic [6:0] SEG_IN;
  logic [3:0] DIGIT_1;
  logic [3:0] DIGIT_10;
  logic       VALID;
  logic       SEG_ERR;
  logic       STALE;

  modport master (
    output CA_IN, SEG_IN,
    input  DIGIT_1, DIGIT_10, VALID, SEG_ERR, STALE
  );

  modport slave (
    input  CA_IN, SEG_IN,
    output DIGIT_1, DIGIT_10, VALID, SEG_ERR, STALE
  );
endinterface

// File: rtl/disp_capture.sv
// Two-digit multiplexed 7-segment display capture with settle filter.
// Optional watchdog: define DISP_CAPTURE_TIMEOUT_EN to enable STALE.
module disp_capture #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic          CLK,
  input logic          RESETN,
  disp_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT
  } state_t;

  localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYC);

  logic       ca_s1, ca_s2, ca_d;
  logic [6:0] seg_s1, seg_s2, seg_d;
  logic       ca_edge;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       sample;

  logic [3:0] pend_1, pend_10;
  logic       flag_1, flag_10;
  logic [3:0] digit_1, digit_10;
  logic       valid, seg_err;

  logic       dec_bad;
  logic [3:0] dec_code;

  // 00 is a blank digit (F); anything not listed is undecodable
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h7e:   r = {1'b0, 4'h0};
      7'h30:   r = {1'b0, 4'h1};
      7'h6d:   r = {1'b0, 4'h2};
      7'h79:   r = {1'b0, 4'h3};
      7'h33:   r = {1'b0, 4'h4};
      7'h5b:   r = {1'b0, 4'h5};
      7'h5f:   r = {1'b0, 4'h6};
      7'h70:   r = {1'b0, 4'h7};
      7'h7f:   r = {1'b0, 4'h8};
      7'h73:   r = {1'b0, 4'h9};
      7'h00:   r = {1'b0, 4'hF};
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  assign {dec_bad, dec_code} = decode(seg_d);
  assign ca_edge = ca_s2 != ca_d;

  // synchronizers plus one-cycle-delayed copies for edge/change detection
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      ca_s1  <= 1'b0;
      ca_s2  <= 1'b0;
      ca_d   <= 1'b0;
      seg_s1 <= '0;
      seg_s2 <= '0;
      seg_d  <= '0;
    end else begin
      ca_s1  <= bus.CA_IN;
      ca_s2  <= ca_s1;
      ca_d   <= ca_s2;
      seg_s1 <= bus.SEG_IN;
      seg_s2 <= seg_s1;
      seg_d  <= seg_s2;
    end
  end

  // phase FSM and stability counter registers
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // a CA edge always restarts settling; sample once SEG held long enough
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sample  = 1'b0;
    if (ca_edge) begin
      state_n = SETTLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        SETTLE: begin
          if (seg_s2 != seg_d) begin
            cnt_n = '0;
          end else if (cnt == SETTLE_LIM) begin
            sample  = 1'b1;
            state_n = WAIT;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // pending capture per phase; publish both digits once a pair is complete
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      pend_1   <= '0;
      pend_10  <= '0;
      flag_1   <= 1'b0;
      flag_10  <= 1'b0;
      digit_1  <= '0;
      digit_10 <= '0;
      valid    <= 1'b0;
      seg_err  <= 1'b0;
    end else begin
      valid   <= 1'b0;
      seg_err <= 1'b0;
      if (flag_1 && flag_10) begin
        digit_1  <= pend_1;
        digit_10 <= pend_10;
        valid    <= 1'b1;
        flag_1   <= 1'b0;
        flag_10  <= 1'b0;
      end
      if (sample) begin
        if (dec_bad) begin
          seg_err <= 1'b1;
          flag_1  <= 1'b0;
          flag_10 <= 1'b0;
        end else if (ca_s2) begin
          pend_10 <= dec_code;
          flag_10 <= 1'b1;
        end else begin
          pend_1 <= dec_code;
          flag_1 <= 1'b1;
        end
      end
    end
  end

  assign bus.DIGIT_1  = digit_1;
  assign bus.DIGIT_10 = digit_10;
  assign bus.VALID    = valid;
  assign bus.SEG_ERR  = seg_err;

`ifdef DISP_CAPTURE_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  logic [15:0] wd;

  // saturating count of cycles since the last CA edge
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wd <= '0;
    end else if (ca_edge) begin
      wd <= '0;
    end else if (wd != 16'hFFFF) begin
      wd <= wd + 16'd1;
    end
  end

  assign bus.STALE = wd >= TO_LIM;
`else
  assign bus.STALE = 1'b0;
`endif

endmodule

// File: tb/tb_disp_capture.sv
// Randomized bench for disp_capture against a phase-level model.
// Define DISP_CAPTURE_TIMEOUT_EN to also exercise the watchdog.
module tb_disp_capture;

  localparam int S = 4;

  logic CLK = 1'b0;
  logic RESETN;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  disp_capture_if bus ();

  disp_capture #(
    .SETTLE_CYC (S),
    .TIMEOUT_CYC(50000)
  ) dut (
    .CLK   (CLK),
    .RESETN(RESETN),
    .bus   (bus.slave)
  );

  logic [6:0] seg_tab [11] = '{
    7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b,
    7'h5f, 7'h70, 7'h7f, 7'h73, 7'h00
  };
  logic [3:0] code_tab [11] = '{
    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
    4'h6, 4'h7, 4'h8, 4'h9, 4'hF
  };

  logic [3:0] m_pend [2];
  bit         m_flag [2];
  logic [3:0] m_d1, m_d10;
  bit         cur_ca;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit lookup(input logic [6:0] s,
                                output logic [3:0] c);
    c = 4'h0;
    for (int k = 0; k < 11; k++)
      if (seg_tab[k] == s) begin
        c = code_tab[k];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic do_reset(input int n);
    bus.CA_IN  = 1'b0;
    bus.SEG_IN = 7'h00;
    RESETN     = 1'b0;
    for (int i = 0; i < n; i++) @(posedge CLK);
    @(negedge CLK);
    check("rst_digit_1", 32'(bus.DIGIT_1), 0);
    check("rst_digit_10", 32'(bus.DIGIT_10), 0);
    check("rst_valid", 32'(bus.VALID), 0);
    check("rst_seg_err", 32'(bus.SEG_ERR), 0);
    check("rst_stale", 32'(bus.STALE), 0);
    RESETN    = 1'b1;
    m_flag[0] = 1'b0;
    m_flag[1] = 1'b0;
    m_pend[0] = 4'h0;
    m_pend[1] = 4'h0;
    m_d1      = 4'h0;
    m_d10     = 4'h0;
    cur_ca    = 1'b0;
  endtask

  // phases of 12+ cycles are fully captured; S+1 or fewer are abandoned
  task automatic phase(input bit ca, input logic [6:0] seg, input int len);
    bit         ok;
    logic [3:0] c;
    int         nv = 0;
    int         ne = 0;
    int         ns = 0;
    int         first = -1;
    int         ev = 0;
    int         ee = 0;
    if (len >= 12) begin
      ok = lookup(seg, c);
      if (!ok) begin
        ee        = 1;
        m_flag[0] = 1'b0;
        m_flag[1] = 1'b0;
      end else begin
        m_pend[ca] = c;
        m_flag[ca] = 1'b1;
        if (m_flag[0] && m_flag[1]) begin
          ev        = 1;
          m_d1      = m_pend[0];
          m_d10     = m_pend[1];
          m_flag[0] = 1'b0;
          m_flag[1] = 1'b0;
        end
      end
    end
    bus.CA_IN  = ca;
    bus.SEG_IN = seg;
    cur_ca     = ca;
    for (int i = 0; i < len; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.VALID) begin
        nv++;
        if (first < 0) first = i;
      end
      if (bus.SEG_ERR) ne++;
      if (bus.STALE) ns++;
    end
    check("valid_cnt", 32'(nv), 32'(ev));
    check("seg_err_cnt", 32'(ne), 32'(ee));
    check("stale_cnt", 32'(ns), 0);
    check("digit_1", 32'(bus.DIGIT_1), 32'(m_d1));
    check("digit_10", 32'(bus.DIGIT_10), 32'(m_d10));
    if (nv > 0) check("latency_ok", 32'(first + 1 <= S + 5), 1);
  endtask

  initial begin
    bit         ca;
    logic [6:0] seg;
    int         len;
    do_reset(3);

    phase(1'b1, 7'h7e, 3);
    phase(1'b0, 7'h30, 20);
    phase(1'b1, 7'h6d, 20);

    phase(1'b0, 7'h73, 20);
    phase(1'b1, 7'h00, 20);

    phase(1'b0, 7'h01, 20);
    phase(1'b1, 7'h7e, 20);
    phase(1'b0, 7'h5b, 20);

    phase(1'b1, 7'h79, 20);
    phase(1'b0, 7'h33, 3);
    phase(1'b1, 7'h5f, 20);
    phase(1'b0, 7'h7f, 20);

    do_reset(1);
    phase(1'b1, 7'h7e, 3);
    phase(1'b0, 7'h30, 20);
    do_reset(1);
    phase(1'b1, 7'h6d, 20);
    phase(1'b0, 7'h79, 20);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
      ca = ~cur_ca;
      if ($urandom_range(0, 5) == 0)
        seg = 7'($urandom);
      else
        seg = seg_tab[$urandom_range(0, 10)];
      if ($urandom_range(0, 3) == 0)
        len = $urandom_range(1, S + 1);
      else
        len = $urandom_range(12, 30);
      phase(ca, seg, len);
    end

`ifdef DISP_CAPTURE_TIMEOUT_EN
    begin
      int waited = 0;
      repeat (50010) @(posedge CLK);
      @(negedge CLK);
      check("stale_set", 32'(bus.STALE), 1);
      bus.CA_IN = ~cur_ca;
      while (bus.STALE && waited < 4) begin
        @(posedge CLK);
        @(negedge CLK);
        waited++;
      end
      check("stale_clear", 32'(bus.STALE), 0);
    end
`else
    begin
      int ns = 0;
      for (int i = 0; i < 300; i++) begin
        @(posedge CLK);
        @(negedge CLK);
        if (bus.STALE) ns++;
      end
      check("stale_tied", 32'(ns), 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
